// File: rtl/core_config_pkg.sv
// Core-wide configuration constants shared by the execute-stage blocks.
package core_config_pkg;
   parameter int XLEN = 32;
endpackage

// File: rtl/shift_issue.sv
// Issue/collect stage that sits in front of the iterative shift unit.
// Optional feature: define SHIFT_ISSUE_ZERO_BYPASS_EN so zero-amount shifts skip the unit.
module shift_issue #(
   parameter int XLEN  = core_config_pkg::XLEN,
   parameter int TAG_W = 5,
   parameter int SHW   = $clog2(XLEN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [XLEN-1:0]  req_rs1,
   input  logic [SHW-1:0]   req_shamt,
   input  logic [TAG_W-1:0] req_tag,
   output logic             sh_start,
   output logic [XLEN-1:0]  sh_data,
   output logic [SHW-1:0]   sh_amount,
   output logic             sh_left,
   output logic             sh_arith,
   input  logic [XLEN-1:0]  sh_data_out,
   input  logic             sh_done,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [XLEN-1:0]  res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             busy
);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, DRAIN} state_t;

   state_t state_reg;
   state_t state_next;
   logic   accept;
   logic   bypass_hit;

   // Gating with rst_n keeps every output low for the whole reset interval.
   assign req_ready = rst_n && (state_reg == IDLE) && !flush;
   assign accept    = req_valid && req_ready;
   assign sh_start  = (state_reg == LAUNCH);
   assign res_valid = (state_reg == RESP) && !flush;
   assign busy      = (state_reg != IDLE);

`ifdef SHIFT_ISSUE_ZERO_BYPASS_EN
   assign bypass_hit = accept && (req_shamt == '0);
`else
   assign bypass_hit = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (bypass_hit)
               state_next = RESP;
            else if (accept)
               state_next = LAUNCH;
         end
         LAUNCH: state_next = flush ? DRAIN : WAIT;
         WAIT: begin
            // The unit cannot abort, so a flush before done must still drain it.
            if (flush)
               state_next = sh_done ? IDLE : DRAIN;
            else if (sh_done)
               state_next = RESP;
         end
         RESP: begin
            if (flush || res_ready)
               state_next = IDLE;
         end
         DRAIN: begin
            if (sh_done)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         sh_data   <= '0;
         sh_amount <= '0;
         sh_left   <= 1'b0;
         sh_arith  <= 1'b0;
         res_data  <= '0;
         res_tag   <= '0;
      end else begin
         state_reg <= state_next;
         if (accept)
            res_tag <= req_tag;
         if (accept && !bypass_hit) begin
            sh_data   <= req_rs1;
            sh_amount <= req_shamt;
            sh_left   <= !req_op[0];
            sh_arith  <= req_op[0] && req_op[1];
         end
         if (bypass_hit)
            res_data <= req_rs1;
         else if ((state_reg == WAIT) && sh_done && !flush)
            res_data <= sh_data_out;
      end
   end

endmodule

// File: tb/tb_shift_issue.sv
// Scoreboard bench for shift_issue with a behavioural 8-bit-per-cycle shift unit.
module tb_shift_issue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = '0;
   logic [31:0] req_rs1 = '0;
   logic [4:0]  req_shamt = '0;
   logic [4:0]  req_tag = '0;
   logic        sh_start;
   logic [31:0] sh_data;
   logic [4:0]  sh_amount;
   logic        sh_left;
   logic        sh_arith;
   logic [31:0] sh_data_out;
   logic        sh_done;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [31:0] res_data;
   logic [4:0]  res_tag;
   logic        busy;

   shift_issue dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rs1(req_rs1), .req_shamt(req_shamt), .req_tag(req_tag),
      .sh_start(sh_start), .sh_data(sh_data), .sh_amount(sh_amount),
      .sh_left(sh_left), .sh_arith(sh_arith), .sh_data_out(sh_data_out),
      .sh_done(sh_done), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_tag(res_tag), .busy(busy)
   );

   always #5 clk = ~clk;

`ifdef SHIFT_ISSUE_ZERO_BYPASS_EN
   localparam int ZLAT = 1;
   localparam int ZSTARTS = 0;
`else
   localparam int ZLAT = 4;
   localparam int ZSTARTS = 1;
`endif

   // Shift unit: done rises ceil(amount/8)+1 edges after the start edge.
   int          u_cnt;
   logic [31:0] u_res;
   assign sh_data_out = u_res;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         u_cnt   <= 0;
         sh_done <= 1'b0;
         u_res   <= '0;
      end else if (sh_start) begin
         sh_done <= 1'b0;
         u_cnt   <= (int'(sh_amount) + 7) / 8 + 1;
         u_res   <= sh_left ? (sh_data << sh_amount)
                  : sh_arith ? 32'($signed(sh_data) >>> sh_amount)
                  : (sh_data >> sh_amount);
      end else if (u_cnt != 0) begin
         u_cnt <= u_cnt - 1;
         if (u_cnt == 1)
            sh_done <= 1'b1;
      end
   end

   int cyc = 0;
   int starts = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && sh_start)
         starts <= starts + 1;
   end

   int checks = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] d;
      logic [4:0]  t;
      int          base;
      int          lat;
   } exp_t;
   exp_t exp_q[$];

   // Monitor: compare every presented result against the queue head.
   logic prev_v = 1'b0;
   always @(negedge clk) begin
      if (rst_n && res_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_res_valid", {31'b0, res_valid}, 32'd0);
         end else begin
            if (!prev_v)
               chk("res_latency", cyc - exp_q[0].base, exp_q[0].lat);
            chk("res_data", res_data, exp_q[0].d);
            chk("res_tag", {27'b0, res_tag}, {27'b0, exp_q[0].t});
            if (res_ready) begin
               $display("result tag=%0d data=0x%08h at cycle %0d", res_tag, res_data, cyc - exp_q[0].base);
               void'(exp_q.pop_front());
            end
         end
      end
      prev_v = rst_n && res_valid;
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Drive one request; returns in cycle 1 after the accepting edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] rs1, input logic [4:0] sh,
                        input logic [4:0] tag, input logic [31:0] exp, input int lat, input bit want);
      int n = 0;
      req_valid = 1'b1;
      req_op = op;
      req_rs1 = rs1;
      req_shamt = sh;
      req_tag = tag;
      #1;
      while (!req_ready && n < 50) begin
         next();
         n++;
      end
      if (!req_ready)
         chk("req_accept_timeout", 32'd0, 32'd1);
      $display("issue op=%0d rs1=0x%08h shamt=%0d tag=%0d", op, rs1, sh, tag);
      if (want)
         exp_q.push_back('{exp, tag, cyc, lat});
      next();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 200) begin
         next();
         n++;
      end
      chk("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] rs1, input logic [4:0] sh,
                         input logic [4:0] tag, input logic [31:0] exp, input int lat, input int nst);
      int s0 = starts;
      issue(op, rs1, sh, tag, exp, lat, 1'b1);
      wait_idle();
      chk("start_count", starts - s0, nst);
   endtask

   task automatic chk_all_zero();
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_sh_start", {31'b0, sh_start}, 32'd0);
      chk("rst_sh_data", sh_data, 32'd0);
      chk("rst_sh_amount", {27'b0, sh_amount}, 32'd0);
      chk("rst_sh_flags", {30'b0, sh_left, sh_arith}, 32'd0);
      chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_res_tag", {27'b0, res_tag}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int s0;
      int n;
      #12;
      chk_all_zero();
      next();
      rst_n = 1'b1;
      next();
      chk("idle_req_ready", {31'b0, req_ready}, 32'd1);

      // Basic decode and latency cases, back to back.
      run_op(2'b00, 32'h0000_0001, 5'd31, 5'd7, 32'h8000_0000, 8, 1);
      run_op(2'b11, 32'h8000_0000, 5'd4, 5'd1, 32'hF800_0000, 5, 1);
      run_op(2'b01, 32'h8000_0000, 5'd4, 5'd2, 32'h0800_0000, 5, 1);
      run_op(2'b10, 32'h0000_0001, 5'd4, 5'd3, 32'h0000_0010, 5, 1);
      run_op(2'b01, 32'hDEAD_BEEF, 5'd0, 5'd9, 32'hDEAD_BEEF, ZLAT, ZSTARTS);

      // Backpressure: hold five cycles in RESP.
      res_ready = 1'b0;
      issue(2'b00, 32'h0000_00A5, 5'd8, 5'd12, 32'h0000_A500, 5, 1'b1);
      n = 0;
      while (!res_valid && n < 50) begin
         next();
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("bp_res_valid", {31'b0, res_valid}, 32'd1);
         chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
         next();
      end
      res_ready = 1'b1;
      next();
      chk("bp_single_transfer", {31'b0, res_valid}, 32'd0);
      wait_idle();

      // Flush in WAIT: drain until the unit finishes.
      s0 = starts;
      issue(2'b00, 32'h0000_0001, 5'd31, 5'd4, 32'h0, 0, 1'b0);
      next();
      flush = 1'b1;
      next();
      flush = 1'b0;
      n = 0;
      while (!sh_done && n < 50) begin
         chk("drain_busy", {31'b0, busy}, 32'd1);
         next();
         n++;
      end
      next();
      chk("drain_done_idle", {31'b0, busy}, 32'd0);
      chk("drain_req_ready", {31'b0, req_ready}, 32'd1);
      chk("drain_starts", starts - s0, 32'd1);
      run_op(2'b00, 32'h0000_0001, 5'd8, 5'd5, 32'h0000_0100, 5, 1);

      // Flush in LAUNCH.
      s0 = starts;
      issue(2'b01, 32'hFFFF_0000, 5'd16, 5'd6, 32'h0, 0, 1'b0);
      flush = 1'b1;
      next();
      flush = 1'b0;
      wait_idle();
      chk("launch_flush_starts", starts - s0, 32'd1);

      // Flush coincident with sh_done in WAIT (shamt 8: done in cycle 4).
      s0 = starts;
      issue(2'b00, 32'h0000_0003, 5'd8, 5'd8, 32'h0, 0, 1'b0);
      next();
      next();
      next();
      chk("coincide_done_seen", {31'b0, sh_done}, 32'd1);
      flush = 1'b1;
      next();
      flush = 1'b0;
      chk("coincide_idle", {31'b0, busy}, 32'd0);
      chk("coincide_starts", starts - s0, 32'd1);

      // Flush in RESP wins over res_ready.
      issue(2'b00, 32'h1234_5678, 5'd0, 5'd10, 32'h0, 0, 1'b0);
      for (int i = 1; i < ZLAT; i++)
         next();
      flush = 1'b1;
      #1;
      chk("resp_flush_valid", {31'b0, res_valid}, 32'd0);
      next();
      flush = 1'b0;
      chk("resp_flush_idle", {31'b0, busy}, 32'd0);

      // Asynchronous reset mid-WAIT.
      issue(2'b11, 32'h8765_4321, 5'd31, 5'd11, 32'h0, 0, 1'b0);
      next();
      next();
      rst_n = 1'b0;
      #1;
      chk_all_zero();
      next();
      next();
      rst_n = 1'b1;
      next();
      run_op(2'b11, 32'h8000_0000, 5'd31, 5'd13, 32'hFFFF_FFFF, 8, 1);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shift_issue.md
# shift_issue

Issue/collect stage directly upstream of the iterative ALU shift unit. Accepts one shift request per transaction over a valid/ready handshake and decodes the op into unit controls. Launches the unit with a single-cycle start pulse and waits for its done. Captures the result and presents it with the destination tag to writeback over a second valid/ready handshake. Also handles pipeline flush, including draining an in-flight shift that the unit cannot abort.

## Interface
- XLEN, core_config_pkg::XLEN, datapath width
- TAG_W, 5, destination register tag width
- SHW, $clog2(XLEN), shift amount width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  kill current transaction
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid & ready
- req_op  in  2  bit0 = right, bit1 = arithmetic: 00 SLL, 01 SRL, 11 SRA, 10 SLL (arith ignored on left)
- req_rs1  in  XLEN  operand
- req_shamt  in  SHW  shift amount
- req_tag  in  TAG_W  destination tag
- sh_start  out  1  one-cycle launch pulse to shift unit
- sh_data  out  XLEN  operand to unit
- sh_amount  out  SHW  amount to unit
- sh_left  out  1  left shift
- sh_arith  out  1  arithmetic right
- sh_data_out  in  XLEN  unit result
- sh_done  in  1  unit done (level; stays high until the unit's next start)
- res_valid  out  1  result valid
- res_ready  in  1  writeback accepts
- res_data  out  XLEN  result
- res_tag  out  TAG_W  tag of result
- busy  out  1  state != IDLE

## Operation
States: IDLE, LAUNCH, WAIT, RESP, DRAIN.
- IDLE: req_ready = !flush. On accept, register rs1, shamt, tag, sh_left = !op[0], sh_arith = op[0] & op[1] -> LAUNCH.
- LAUNCH: sh_start = 1 for exactly this cycle, sh_* driven from registers. Next state is WAIT, or DRAIN if flush.
- WAIT: sh_done sampled only in this state; a stale done level from a prior op is never observed here.
  - On sh_done, capture sh_data_out into res_data -> RESP.
  - Flush with sh_done in the same cycle: discard -> IDLE.
  - Flush without sh_done: -> DRAIN.
- RESP: res_valid = !flush. On res_valid & res_ready -> IDLE. Flush -> IDLE; result dropped, and flush wins over a simultaneous res_ready.
- DRAIN: wait for sh_done, then -> IDLE with no result. A flush arriving in DRAIN has no further effect.
- req_ready is 0 in every state except IDLE. sh_* operand outputs hold their last value outside LAUNCH.
- Reset, asynchronous at any point including mid-shift: state IDLE; all outputs 0. The shift unit is reset by the same rst_n, so no drain is needed.

## Timing
- Accept at edge E0. LAUNCH occupies cycle 1 after E0.
- Let M = MAX_SHIFT_PER_CYCLE and k = ceil(shamt/M). sh_done rises in cycle 3+k.
- res_valid first asserts in cycle 4+k and holds with stable res_data/res_tag until accepted.
- shamt = 0 without bypass: res_valid at cycle 4.
- Back-to-back: a new request can be accepted in the first IDLE cycle after RESP completes.

## Configuration
- SHIFT_ISSUE_ZERO_BYPASS_EN defined:
  - Accept with shamt == 0 goes directly IDLE -> RESP with res_data = rs1. No sh_start is issued. res_valid at cycle 1.
  - Flush in that RESP behaves as above.
- Undefined: every request, including shamt 0, goes through the unit.

## Test plan
Bench uses M = 8, XLEN = 32, res_ready = 1 unless stated.
- SLL rs1 0x0000_0001, shamt 31, tag 7 -> exactly one sh_start; res_valid at cycle 8 with res_data 0x8000_0000, res_tag 7.
- SRA 0x8000_0000 by 4 -> 0xF800_0000. SRL 0x8000_0000 by 4 -> 0x0800_0000. Op 10 by 4 on 0x1 -> 0x10.
- Backpressure: res_ready low 5 cycles in RESP -> res_valid, data and tag stable; req_ready stays 0; one transfer on release.
- Flush in WAIT with shamt 31 -> no res_valid; busy stays high until sh_done; req_ready = 1 in the following cycle. Next request returns a correct result.
- Flush in LAUNCH, and flush coincident with sh_done in WAIT -> no result, no second sh_start, returns to IDLE.
- shamt 0: with the macro, res_valid at cycle 1 with no sh_start; without it, res_valid at cycle 4. Assert rst_n low mid-WAIT -> all outputs 0 immediately, and a fresh request completes normally.
